counter_ctrl: RTL and testbench

- Sequencing controller for the shared W-bit up-counter.
- Drives the counter's synchronous clear and count-enable.
- Watches the counter's output and stops it at a programmed limit.
- Repeats the count pass N times, or indefinitely in periodic mode.
- Reports busy, per-pass pulses and a final done pulse to the host logic.

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_ctrl.sv | 136 +++++++++++++
 tb/tb_counter_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencing controller.
//
// Contents:
//   state_t         controller state: IDLE, CLR, RUN (2-bit encoding)
//   DEFAULT_W       default width of the controlled up-counter
//   DEFAULT_RPT_W   default width of the repeat-count field / passes_left
package counter_pkg;

    localparam int DEFAULT_W     = 4;
    localparam int DEFAULT_RPT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/counter_ctrl.sv
// Sequencing controller for a shared W-bit up-counter.
//
// The controller clears the counter, then lets it count up to a limit that is
// latched at start. The counter stops there. The clear-and-count pass repeats
// repeat_n times, or forever in periodic mode. Passes end early only on abort.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        begin a job (accepted only while idle)
//   abort        return to idle from any state, no completion pulses
//   pause        holds the counter while running
//   limit        terminal count, latched on start
//   repeat_n     number of passes, latched on start (0 means 1)
//   periodic     latched on start; 1 = repeat passes until abort
//   cnt_q        current value of the controlled counter
//   cnt_clr      synchronous clear to the counter
//   cnt_en       count enable to the counter
//   busy         high whenever not idle
//   pass_done    1-cycle pulse after each completed pass
//   done         1-cycle pulse after the final pass
//   passes_left  passes remaining, including the current one
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int RPT_W = DEFAULT_RPT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [W-1:0]     limit,
    input  logic [RPT_W-1:0] repeat_n,
    input  logic             periodic,
    input  logic [W-1:0]     cnt_q,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic             pass_done,
    output logic             done,
    output logic [RPT_W-1:0] passes_left
);

    state_t           state;
    state_t           next_state;
    logic [W-1:0]     limit_r;
    logic             periodic_r;
    logic             term;
    logic             last_pass;
    logic             load;
    logic             end_pass;
    logic             end_job;
    logic [RPT_W-1:0] rpt_eff;

    // A repeat count of zero runs a single pass.
    assign rpt_eff   = (repeat_n == '0) ? RPT_W'(1) : repeat_n;
    assign term      = (cnt_q == limit_r);
    // Written as <= so that passes_left can never wrap below zero.
    assign last_pass = (passes_left <= RPT_W'(1));

    // Next-state logic. Priority in RUN is abort, then terminal count.
    // Pause affects only the count enable.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        end_pass   = 1'b0;
        end_job    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    next_state = CLR;
                    load       = 1'b1;
                end
            end
            CLR: begin
                next_state = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (term) begin
                    end_pass = 1'b1;
                    if (periodic_r) begin
                        next_state = CLR;
                    end else if (last_pass) begin
                        next_state = IDLE;
                        end_job    = 1'b1;
                    end else begin
                        next_state = CLR;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counter controls are decoded combinationally. The enable drops on the
    // terminal count so that the counter holds at the limit.
    always_comb begin
        cnt_clr = (state == CLR);
        cnt_en  = (state == RUN) && !pause && !abort && !term;
        busy    = (state != IDLE);
    end

    // State, the job parameters latched on start, and the registered pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            limit_r     <= '0;
            periodic_r  <= 1'b0;
            passes_left <= '0;
            pass_done   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state     <= next_state;
            pass_done <= end_pass;
            done      <= end_job;
            if (load) begin
                limit_r    <= limit;
                periodic_r <= periodic;
            end
            if (abort) begin
                passes_left <= '0;
            end else if (load) begin
                passes_left <= rpt_eff;
            end else if (end_pass && !periodic_r) begin
                passes_left <= last_pass ? '0 : passes_left - RPT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl, with a behavioural up-counter.
// Non-periodic jobs are compared against an expected cycle trace. The trace is
// built from the pass-timing rules: one clear cycle, then counting 0..limit,
// with extra held cycles wherever pause is drawn.
module tb_counter_ctrl;

    localparam int W     = 4;
    localparam int RPT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             pause = 1'b0;
    logic [W-1:0]     limit = '0;
    logic [RPT_W-1:0] repeat_n = '0;
    logic             periodic = 1'b0;
    logic [W-1:0]     cnt_q = '0;
    logic             cnt_clr;
    logic             cnt_en;
    logic             busy;
    logic             pass_done;
    logic             done;
    logic [RPT_W-1:0] passes_left;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit pause;
        int q;
        bit chk_q;
        bit en;
        bit clr;
        bit busy;
        int pl;
        bit pd;
        bit dn;
    } rec_t;

    always #5 clk = ~clk;

    // The shared counter that the controller drives.
    always_ff @(posedge clk) begin
        if (cnt_clr) cnt_q <= '0;
        else if (cnt_en) cnt_q <= cnt_q + 1'b1;
    end

    counter_ctrl #(.W(W), .RPT_W(RPT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .limit(limit), .repeat_n(repeat_n), .periodic(periodic), .cnt_q(cnt_q),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .busy(busy), .pass_done(pass_done),
        .done(done), .passes_left(passes_left)
    );

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, cnt_clr, cnt_en, pass_done, done} !== 5'b0 || passes_left !== '0) begin
            failures++;
            $display("[TB] FAIL reset outputs actual busy=%0b clr=%0b en=%0b pd=%0b done=%0b pl=%0d required all 0",
                     busy, cnt_clr, cnt_en, pass_done, done, passes_left);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Run one non-periodic job and compare every cycle with the expected trace.
    // prob is the percent chance of pause in any cycle.
    task automatic test_job(input int lim, input int rpt, input int prob);
        rec_t tr[$];
        rec_t r;
        int   np;
        int   busy_cycles;
        int   pause_cycles;
        np = (rpt == 0) ? 1 : rpt;
        pause_cycles = 0;
        for (int p = 0; p < np; p++) begin
            r = '{pause: ($urandom_range(0, 99) < prob), q: 0, chk_q: 0, en: 0, clr: 1,
                  busy: 1, pl: np - p, pd: (p > 0), dn: 0};
            tr.push_back(r);
            for (int k = 0; k <= lim; k++) begin
                if (k < lim) begin
                    while ($urandom_range(0, 99) < prob) begin
                        r = '{pause: 1, q: k, chk_q: 1, en: 0, clr: 0, busy: 1, pl: np - p, pd: 0, dn: 0};
                        tr.push_back(r);
                        pause_cycles++;
                    end
                    r = '{pause: 0, q: k, chk_q: 1, en: 1, clr: 0, busy: 1, pl: np - p, pd: 0, dn: 0};
                end else begin
                    r = '{pause: ($urandom_range(0, 99) < prob), q: k, chk_q: 1, en: 0, clr: 0,
                          busy: 1, pl: np - p, pd: 0, dn: 0};
                end
                tr.push_back(r);
            end
        end
        r = '{pause: 0, q: lim, chk_q: 1, en: 0, clr: 0, busy: 0, pl: 0, pd: 1, dn: 1};
        tr.push_back(r);

        @(negedge clk);
        limit = W'(lim);
        repeat_n = RPT_W'(rpt);
        periodic = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        start = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            pause = tr[i].pause;
            // Start pulses and parameter changes while busy must be ignored.
            start = (i < tr.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (start) begin
                limit = W'($urandom);
                repeat_n = RPT_W'($urandom);
                periodic = 1'($urandom);
            end
            #1;
            if (busy) busy_cycles++;
            checks++;
            if (busy !== tr[i].busy || cnt_clr !== tr[i].clr || cnt_en !== tr[i].en) begin
                failures++;
                $display("[TB] FAIL job ctl cyc=%0d actual busy/clr/en=%0b%0b%0b required=%0b%0b%0b",
                         i, busy, cnt_clr, cnt_en, tr[i].busy, tr[i].clr, tr[i].en);
            end
            checks++;
            if (passes_left !== RPT_W'(tr[i].pl) || pass_done !== tr[i].pd || done !== tr[i].dn) begin
                failures++;
                $display("[TB] FAIL job status cyc=%0d actual pl=%0d pd=%0b done=%0b required pl=%0d pd=%0b done=%0b",
                         i, passes_left, pass_done, done, tr[i].pl, tr[i].pd, tr[i].dn);
            end
            if (tr[i].chk_q) begin
                checks++;
                if (cnt_q !== W'(tr[i].q)) begin
                    failures++;
                    $display("[TB] FAIL job cnt_q cyc=%0d actual=%0d required=%0d", i, cnt_q, tr[i].q);
                end
            end
        end
        pause = 1'b0;
        checks++;
        if (busy_cycles != np * (lim + 2) + pause_cycles) begin
            failures++;
            $display("[TB] FAIL job busy_time actual=%0d required=%0d", busy_cycles, np * (lim + 2) + pause_cycles);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || pass_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL job pulse_width actual done=%0b pd=%0b busy=%0b required 0 0 0", done, pass_done, busy);
        end
    endtask

    task automatic test_pause();
        @(negedge clk);
        limit = 4'd9;
        repeat_n = 8'd1;
        periodic = 1'b0;
        start = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
            pause = (c >= 4 && c <= 7);
            #1;
            if (c >= 4 && c <= 8) begin
                checks++;
                if (cnt_q !== 4'd3 || cnt_en !== (c == 8)) begin
                    failures++;
                    $display("[TB] FAIL pause hold c=%0d actual q=%0d en=%0b required q=3 en=%0b",
                             c, cnt_q, cnt_en, (c == 8));
                end
            end
            checks++;
            if (busy !== (c < 15) || done !== (c == 15)) begin
                failures++;
                $display("[TB] FAIL pause timing c=%0d actual busy=%0b done=%0b required busy=%0b done=%0b",
                         c, busy, done, (c < 15), (c == 15));
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_periodic_abort();
        @(negedge clk);
        limit = 4'd3;
        repeat_n = 8'd7;
        periodic = 1'b1;
        start = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++;
            if (pass_done !== (c > 0 && c % 5 == 0) || done !== 1'b0 || passes_left !== 8'd7 ||
                cnt_clr !== (c % 5 == 0) || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL periodic c=%0d actual pd=%0b done=%0b pl=%0d clr=%0b busy=%0b",
                         c, pass_done, done, passes_left, cnt_clr, busy);
            end
        end
        @(negedge clk);
        abort = 1'b1;
        #1;
        checks++;
        if (cnt_en !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort gate actual en=%0b busy=%0b required en=0 busy=1", cnt_en, busy);
        end
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass_done !== 1'b0 || passes_left !== '0 || cnt_q !== 4'd1) begin
            failures++;
            $display("[TB] FAIL abort idle actual busy=%0b done=%0b pd=%0b pl=%0d q=%0d required 0 0 0 0 1",
                     busy, done, pass_done, passes_left, cnt_q);
        end
        periodic = 1'b0;
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        limit = 4'd5;
        repeat_n = 8'd2;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cnt_clr !== 1'b0 || passes_left !== '0) begin
            failures++;
            $display("[TB] FAIL start_abort actual busy=%0b clr=%0b pl=%0d required 0 0 0", busy, cnt_clr, passes_left);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        limit = 4'd9;
        repeat_n = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cnt_en !== 1'b0 || done !== 1'b0 || passes_left !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset actual busy=%0b en=%0b done=%0b pl=%0d required 0 0 0 0",
                     busy, cnt_en, done, passes_left);
        end
        @(negedge clk);
        rst = 1'b1;
        test_job(4, 2, 0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 20; j++) begin
            test_job($urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(0, 40));
        end
    endtask

    initial begin
        test_reset();
        test_job(5, 1, 0);
        test_job(2, 3, 0);
        test_job(0, 1, 0);
        test_job(3, 0, 0);
        test_pause();
        test_periodic_abort();
        test_start_abort();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
